// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize, debounce and edge-detect four push buttons
//   Ports: ClkPort (clock), ResetN (async active-low reset),
//          BtnRaw[3:0] raw pins {L,R,U,C}, BtnLevel[3:0] debounced held level,
//          BtnPress[3:0] one-cycle pulse per accepted press (or repeat).
//   Optional auto-repeat for buttons selected by REPEAT_MASK: `define BTN_AUTOREPEAT_EN
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY = 30_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter logic [3:0] REPEAT_MASK = 4'b1100
) (
  input  logic       ClkPort,
  input  logic       ResetN,
  input  logic [3:0] BtnRaw,
  output logic [3:0] BtnLevel,
  output logic [3:0] BtnPress
);
  typedef enum logic [1:0] {RELEASED, MAYBE_PRESS, PRESSED, MAYBE_RELEASE} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || $bits(REPEAT_MASK) != 4) begin : g_bad_param
    $error("btn_conditioner: illegal parameter value");
  end
  logic [3:0] sync0, sync1;
  state_t state [4];
  state_t state_nx [4];
  logic [CW-1:0] cnt [4];
  logic [CW-1:0] cnt_nx [4];
  logic [3:0] accept, level_nx, press_nx;
  always_ff @(posedge ClkPort or negedge ResetN) begin
    if (!ResetN) begin
      sync0 <= '0;
      sync1 <= '0;
      BtnLevel <= '0;
      BtnPress <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i] <= '0;
      end
    end else begin
      sync0 <= BtnRaw;
      sync1 <= sync0;
      BtnLevel <= level_nx;
      BtnPress <= press_nx;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nx[i];
        cnt[i] <= cnt_nx[i];
      end
    end
  end
  // Compare-before-increment keeps cnt within DEBOUNCE_CYCLES-1, so it never wraps.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i] = cnt[i];
      accept[i] = 1'b0;
      case (state[i])
        RELEASED: if (sync1[i]) begin
          state_nx[i] = MAYBE_PRESS;
          cnt_nx[i] = '0;
        end
        MAYBE_PRESS: if (!sync1[i]) begin
          state_nx[i] = RELEASED;
          cnt_nx[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          state_nx[i] = PRESSED;
          accept[i] = 1'b1;
        end else cnt_nx[i] = cnt[i] + 1'b1;
        PRESSED: if (!sync1[i]) begin
          state_nx[i] = MAYBE_RELEASE;
          cnt_nx[i] = '0;
        end
        default: if (sync1[i]) state_nx[i] = PRESSED;
          else if (cnt[i] == CNT_LAST) state_nx[i] = RELEASED;
          else cnt_nx[i] = cnt[i] + 1'b1;
      endcase
      level_nx[i] = state_nx[i] == PRESSED || state_nx[i] == MAYBE_RELEASE;
    end
  end
`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rcnt [4];
  logic [RW-1:0] rcnt_nx [4];
  logic [3:0] first, first_nx, rep;
  always_ff @(posedge ClkPort or negedge ResetN) begin
    if (!ResetN) begin
      first <= '0;
      for (int i = 0; i < 4; i++) rcnt[i] <= '0;
    end else begin
      first <= first_nx;
      for (int i = 0; i < 4; i++) rcnt[i] <= rcnt_nx[i];
    end
  end
  // first marks that the initial REPEAT_DELAY interval is still running;
  // the timer keeps going through a bounce back from MAYBE_RELEASE.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rcnt_nx[i] = rcnt[i];
      first_nx[i] = first[i];
      rep[i] = 1'b0;
      if (accept[i]) begin
        rcnt_nx[i] = '0;
        first_nx[i] = 1'b1;
      end else if (REPEAT_MASK[i] && BtnLevel[i] && level_nx[i]) begin
        if (rcnt[i] == (first[i] ? DELAY_LAST : PERIOD_LAST)) begin
          rep[i] = 1'b1;
          rcnt_nx[i] = '0;
          first_nx[i] = 1'b0;
        end else rcnt_nx[i] = rcnt[i] + 1'b1;
      end
    end
    press_nx = accept | (rep & REPEAT_MASK);
  end
`else
  assign press_nx = accept;
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner with short debounce/repeat timing
module tb_btn_conditioner;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  typedef struct {
    int cyc;
    logic [3:0] press;
  } ev_t;
  logic ClkPort = 1'b0;
  logic ResetN = 1'b0;
  logic [3:0] BtnRaw = 4'b0;
  logic [3:0] BtnLevel, BtnPress;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t sb[$];
  btn_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(4'b1100)
  ) dut (
    .ClkPort(ClkPort),
    .ResetN(ResetN),
    .BtnRaw(BtnRaw),
    .BtnLevel(BtnLevel),
    .BtnPress(BtnPress)
  );
  always #5 ClkPort = ~ClkPort;
  always @(posedge ClkPort) cyc <= cyc + 1;
  // Expected press events are queued with the edge count after which they must be visible.
  always @(negedge ClkPort) begin
    ev_t e;
    if (ResetN) begin
      if (BtnPress != 4'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL press_unexpected cyc=%0d got=%b expected=none", cyc, BtnPress);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.press !== BtnPress) begin
            errors++;
            $display("FAIL press_event got cyc=%0d val=%b expected cyc=%0d val=%b", cyc, BtnPress, e.cyc, e.press);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL press_missing cyc=%0d got=%b expected=%b", cyc, BtnPress, e.press);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge ClkPort);
  endtask
  task automatic test_reset;
    ResetN = 1'b0;
    BtnRaw = 4'b0;
    repeat (3) @(negedge ClkPort);
    checks++;
    if ({BtnLevel, BtnPress} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=00000000", {BtnLevel, BtnPress});
    end
    ResetN = 1'b1;
    repeat (2) @(negedge ClkPort);
    checks++;
    if ({BtnLevel, BtnPress} !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got=%b expected=00000000", {BtnLevel, BtnPress});
    end
  endtask
  task automatic test_clean_press;
    int k;
    @(negedge ClkPort);
    k = cyc;
    BtnRaw[0] = 1'b1;
    sb.push_back('{k + 7, 4'b0001});
    wait_to(k + 6);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL clean_level_early got=%b expected=0000", BtnLevel);
    end
    wait_to(k + 7);
    checks++;
    if (BtnLevel !== 4'b0001 || BtnPress !== 4'b0001) begin
      errors++;
      $display("FAIL clean_accept got level=%b press=%b expected level=0001 press=0001", BtnLevel, BtnPress);
    end
    wait_to(k + 8);
    checks++;
    if (BtnLevel !== 4'b0001 || BtnPress !== 4'b0000) begin
      errors++;
      $display("FAIL clean_after got level=%b press=%b expected level=0001 press=0000", BtnLevel, BtnPress);
    end
  endtask
  task automatic test_release_bounce;
    int f;
    BtnRaw[0] = 1'b0;
    repeat (2) @(negedge ClkPort);
    BtnRaw[0] = 1'b1;
    repeat (2) @(negedge ClkPort);
    BtnRaw[0] = 1'b0;
    f = cyc;
    for (int c = f + 1; c <= f + 6; c++) begin
      wait_to(c);
      checks++;
      if (BtnLevel !== 4'b0001) begin
        errors++;
        $display("FAIL bounce_level_held cyc=%0d got=%b expected=0001", cyc, BtnLevel);
      end
    end
    wait_to(f + 7);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_level_drop got=%b expected=0000", BtnLevel);
    end
  endtask
  task automatic test_glitch;
    int k;
    @(negedge ClkPort);
    k = cyc;
    BtnRaw[3] = 1'b1;
    repeat (3) @(negedge ClkPort);
    BtnRaw[3] = 1'b0;
    for (int c = k + 1; c <= k + 12; c++) begin
      wait_to(c);
      checks++;
      if (BtnLevel !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_level cyc=%0d got=%b expected=0000", cyc, BtnLevel);
      end
    end
  endtask
  task automatic test_simultaneous;
    int k;
    @(negedge ClkPort);
    k = cyc;
    BtnRaw = 4'b0101;
    sb.push_back('{k + 7, 4'b0101});
    wait_to(k + 7);
    checks++;
    if (BtnLevel !== 4'b0101 || BtnPress !== 4'b0101) begin
      errors++;
      $display("FAIL simul_accept got level=%b press=%b expected level=0101 press=0101", BtnLevel, BtnPress);
    end
    BtnRaw = 4'b0000;
    wait_to(k + 13);
    checks++;
    if (BtnLevel !== 4'b0101) begin
      errors++;
      $display("FAIL simul_hold got=%b expected=0101", BtnLevel);
    end
    wait_to(k + 15);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL simul_release got=%b expected=0000", BtnLevel);
    end
  endtask
  task automatic test_reset_mid_hold;
    int k, m;
    @(negedge ClkPort);
    k = cyc;
    BtnRaw[1] = 1'b1;
    sb.push_back('{k + 7, 4'b0010});
    wait_to(k + 9);
    checks++;
    if (BtnLevel !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_held got=%b expected=0010", BtnLevel);
    end
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if ({BtnLevel, BtnPress} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async_clear got=%b expected=00000000", {BtnLevel, BtnPress});
    end
    repeat (2) @(negedge ClkPort);
    ResetN = 1'b1;
    m = cyc;
    sb.push_back('{m + 7, 4'b0010});
    wait_to(m + 6);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_relatch_early got=%b expected=0000", BtnLevel);
    end
    wait_to(m + 7);
    checks++;
    if (BtnLevel !== 4'b0010 || BtnPress !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_repress got level=%b press=%b expected level=0010 press=0010", BtnLevel, BtnPress);
    end
    BtnRaw[1] = 1'b0;
    wait_to(m + 16);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_release got=%b expected=0000", BtnLevel);
    end
  endtask
  task automatic test_auto_repeat;
    int k;
    @(negedge ClkPort);
    k = cyc;
    BtnRaw[2] = 1'b1;
    sb.push_back('{k + 7, 4'b0100});
`ifdef BTN_AUTOREPEAT_EN
    for (int t = k + 7 + RD; t <= k + 45; t += RP) sb.push_back('{t, 4'b0100});
`endif
    repeat (38) @(negedge ClkPort);
    checks++;
    if (BtnLevel !== 4'b0100) begin
      errors++;
      $display("FAIL repeat_r_held got=%b expected=0100", BtnLevel);
    end
    BtnRaw[2] = 1'b0;
    wait_to(k + 50);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL repeat_r_release got=%b expected=0000", BtnLevel);
    end
    @(negedge ClkPort);
    k = cyc;
    BtnRaw[1] = 1'b1;
    sb.push_back('{k + 7, 4'b0010});
    repeat (40) @(negedge ClkPort);
    checks++;
    if (BtnLevel !== 4'b0010) begin
      errors++;
      $display("FAIL repeat_u_held got=%b expected=0010", BtnLevel);
    end
    BtnRaw[1] = 1'b0;
    wait_to(k + 55);
    checks++;
    if (BtnLevel !== 4'b0000) begin
      errors++;
      $display("FAIL repeat_u_release got=%b expected=0000", BtnLevel);
    end
  endtask
  initial begin
    test_reset;
    test_clean_press;
    test_release_bounce;
    test_glitch;
    test_simultaneous;
    test_reset_mid_hold;
    test_auto_repeat;
    repeat (5) @(negedge ClkPort);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the four raw push-button inputs (BtnC, BtnU, BtnR, BtnL) before they reach the game logic. It synchronizes each button to ClkPort, debounces it, and produces a clean held level plus a one-cycle press pulse per button. It sits between the board pins and the VGA game logic in the top level, replacing the direct pin connections. The optional auto-repeat lets a held left/right button generate periodic move pulses.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- REPEAT_DELAY, 30_000_000: cycles from the accepted press to the first repeat pulse; legal range ≥ 1. Used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat pulses; legal range ≥ 1. Used only with BTN_AUTOREPEAT_EN.
- REPEAT_MASK, 4'b1100: per-button auto-repeat enable, bit order {L,R,U,C}.
- ClkPort  in  1  system clock, 100 MHz, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- BtnRaw  in  4  raw pins {BtnL,BtnR,BtnU,BtnC}; asynchronous.
- BtnLevel  out  4  debounced level per button, 1 = held.
- BtnPress  out  4  one-cycle pulse per accepted press (or repeat).

## Operation
- Per-bit two-flop synchronizer, sync0 → sync1. Both flops reset to 0. All later logic uses sync1 only.
- Independent per-button FSM, 4 states: RELEASED, MAYBE_PRESS, PRESSED, MAYBE_RELEASE. Each button has its own debounce counter, cnt, of width clog2(DEBOUNCE_CYCLES).
- RELEASED: if sync1 = 1, go to MAYBE_PRESS with cnt = 0.
- MAYBE_PRESS:
  - If sync1 = 0, return to RELEASED with cnt = 0.
  - If sync1 = 1 and cnt = DEBOUNCE_CYCLES−1, go to PRESSED and fire the BtnPress pulse.
  - Otherwise cnt++.
- PRESSED: if sync1 = 0, go to MAYBE_RELEASE with cnt = 0.
- MAYBE_RELEASE, symmetric to MAYBE_PRESS:
  - If sync1 = 1, return to PRESSED. This does not reset the repeat timer and does not produce a pulse.
  - If sync1 = 0 for DEBOUNCE_CYCLES cycles, go to RELEASED. No pulse on release.
- BtnLevel = 1 in PRESSED and MAYBE_RELEASE; 0 otherwise. It is registered.
- BtnPress is registered and high for exactly one cycle per event.
- Glitches shorter than DEBOUNCE_CYCLES never change BtnLevel and never pulse.
- Buttons are fully independent. Simultaneous presses on several buttons pulse in the same cycle.
- Counters saturate by design and never wrap, because the compare happens before the increment.

## Timing
- Reset values: all outputs 0, all FSMs RELEASED, counters 0, synchronizers 0.
- Press latency, for a raw high held stable from edge E:
  - sync1 = 1 after edge E+1.
  - MAYBE_PRESS after edge E+2.
  - PRESSED, BtnLevel = 1 and BtnPress = 1 after edge E+2+DEBOUNCE_CYCLES.
  - BtnPress returns to 0 one edge later.
- Release latency: BtnLevel falls after edge E+2+DEBOUNCE_CYCLES, measured from the first sampled low.
- Reset mid-operation: every state clears immediately and asynchronously. A button still held when reset deasserts is treated as a new press and pulses after the full press latency.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - Each button with its REPEAT_MASK bit set has a repeat counter, cleared on entry to PRESSED from MAYBE_PRESS.
  - While in PRESSED or MAYBE_RELEASE, the first repeat BtnPress pulse occurs REPEAT_DELAY cycles after the accepted-press pulse.
  - Further pulses follow every REPEAT_PERIOD cycles until the FSM reaches RELEASED.
  - Masked-off buttons behave as in the undefined case.
- BTN_AUTOREPEAT_EN undefined: no repeat logic is instantiated; exactly one BtnPress pulse per accepted press. The REPEAT_* parameters are ignored.

## Test plan
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: ResetN low for 3 cycles, release; BtnRaw[0]=1 held from edge 10 → BtnLevel[0]=1 and BtnPress[0]=1 after edge 16; BtnPress[0]=0 after edge 17; no other bit changes.
- Glitch: BtnRaw[3] high for 3 cycles, then low → BtnLevel and BtnPress stay 0 throughout.
- Bounce on release: held button's raw goes 0 for 2 cycles, 1 for 2, 0 for good → BtnLevel drops only 6 edges after the final fall; no extra BtnPress.
- Simultaneous: BtnRaw=4'b0101 on the same edge → BtnPress=4'b0101 in one cycle, BtnLevel=4'b0101.
- Reset mid-hold: ResetN pulled low while BtnLevel[1]=1 → outputs 0 immediately; after ResetN rises with the button still held, BtnPress[1] pulses 6 edges later.
- Auto-repeat (macro defined): hold BtnRaw[2] (R) for 40 cycles → pulses at the accepted press, then +10, +15, +20…; hold BtnRaw[1] (U) for 40 cycles → exactly one pulse.
